// File: rtl/pmem_dat_arbiter.sv
// Two-master round-robin arbiter for the program-memory Wishbone data port.
// The grant is registered and stays with the owner while it holds CYC.
module pmem_dat_arbiter #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 16
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    // 1 = M1 was the most recent owner, so M0 wins the next tie
    logic   last_owner;
    logic   last_owner_nxt;

    // State and round-robin history registers
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next-state: grant held while owner CYC is high, direct hand-off on release
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (m0_cyc_i && !m1_cyc_i) begin
                    state_nxt = G0;
                end else if (m1_cyc_i && !m0_cyc_i) begin
                    state_nxt = G1;
                end else if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_owner ? G0 : G1;
                end
            end
            G0: begin
                if (!m0_cyc_i) begin
                    last_owner_nxt = 1'b0;
                    state_nxt      = m1_cyc_i ? G1 : IDLE;
                end
            end
            G1: begin
                if (!m1_cyc_i) begin
                    last_owner_nxt = 1'b1;
                    state_nxt      = m0_cyc_i ? G0 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output mux: owner drives the slave, slave ack routed only to the owner
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        gnt_o    = 2'b00;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        case (state)
            G0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                gnt_o    = 2'b01;
            end
            G1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                gnt_o    = 2'b10;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_dat_arbiter.sv
// Directed bench for pmem_dat_arbiter with a registered-ack memory model.
module tb_pmem_dat_arbiter;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic          sys_clk_i;
    logic          sys_rst_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic          m0_we_i;
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic          m1_we_i;
    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o;
    logic          s_cyc_o;
    logic          s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    // memory model state
    logic          mem_rst_n;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          spur_ack;
    logic          bk_we;
    logic [AW-1:0] bk_adr;
    logic [DW-1:0] bk_dat;

    int total;
    int bad;
    int a0;
    int a1;

    pmem_dat_arbiter #(.AW(AW), .DW(DW)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_we_i   (m0_we_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_we_i   (m1_we_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .gnt_o     (gnt_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    // Memory acks one cycle after it sees a strobe (request+2 from IDLE)
    always @(posedge sys_clk_i or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ack <= s_cyc_o & s_stb_o & ~mem_ack;
            if (bk_we) begin
                mem[bk_adr] <= bk_dat;
            end else if (s_cyc_o && s_stb_o && !mem_ack) begin
                if (s_we_o) mem[s_adr_o] <= s_dat_o;
                mem_rdata <= mem[s_adr_o];
            end
        end
    end

    assign s_ack_i = mem_ack | spur_ack;
    assign s_dat_i = mem_rdata;

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_acks();
        if (m0_ack_o) a0++;
        if (m1_ack_o) a1++;
    endtask

    initial begin
        total = 0; bad = 0; a0 = 0; a1 = 0;
        sys_rst_i = 1'b0; mem_rst_n = 1'b0; spur_ack = 1'b0;
        bk_we = 1'b0; bk_adr = '0; bk_dat = '0;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_sstb", 32'(s_stb_o), 32'h0);
        tick();
        mem_rst_n = 1'b1;
        bk_we = 1'b1; bk_adr = 13'h0010; bk_dat = 16'hBEEF;
        tick();
        bk_we = 1'b0;
        sys_rst_i = 1'b1;

        // 1: single M0 read
        m0_adr_i = 13'h0010; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1 chk("s1_gnt_idle", 32'(gnt_o), 32'h0);
        tick();
        chk("s1_gnt", 32'(gnt_o), 32'h1);
        chk("s1_ack_early", 32'(m0_ack_o), 32'h0);
        tick();
        chk("s1_ack", 32'(m0_ack_o), 32'h1);
        chk("s1_dat", 32'(m0_dat_o), 32'hBEEF);
        chk("s1_m1ack", 32'(m1_ack_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("s1_ack_single", 32'(m0_ack_o), 32'h0);
        chk("s1_idle", 32'(gnt_o), 32'h0);

        // 2: tie after reset goes to M0, then direct hand-off to M1 write
        sys_rst_i = 1'b0;
        tick();
        sys_rst_i = 1'b1;
        m0_adr_i = 13'h0010; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 13'h0200; m1_dat_i = 16'h1234; m1_we_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("s2_gnt_m0", 32'(gnt_o), 32'h1);
        tick();
        chk("s2_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("s2_m1_wait", 32'(m1_ack_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("s2_handoff", 32'(gnt_o), 32'h2);
        chk("s2_s_adr", 32'(s_adr_o), 32'h0200);
        tick();
        chk("s2_m1_ack", 32'(m1_ack_o), 32'h1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        tick();
        chk("s2_mem", 32'(mem[13'h0200]), 32'h1234);

        // 3: make M0 last, then ties alternate starting with M1
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        tick();
        chk("s3_m0_ack", 32'(m0_ack_o), 32'h1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
            tick();
            chk($sformatf("s3_tie%0d", i), 32'(gnt_o), (i % 2 == 0) ? 32'h2 : 32'h1);
            m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
            tick();
        end

        // 4: M1 locked 4-beat burst while M0 waits
        a0 = 0; a1 = 0;
        m1_cyc_i = 1'b1; m1_we_i = 1'b1;
        tick();
        m0_adr_i = 13'h0010; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m1_adr_i = 13'(13'h0300 + b);
            m1_dat_i = 16'(16'hA000 + b);
            m1_stb_i = 1'b1;
            tick();
            count_acks();
            m1_stb_i = 1'b0;
            tick();
            count_acks();
        end
        chk("s4_m1_acks", 32'(a1), 32'd4);
        chk("s4_m0_acks", 32'(a0), 32'd0);
        chk("s4_mem", 32'(mem[13'h0303]), 32'hA003);
        m1_cyc_i = 1'b0; m1_we_i = 1'b0;
        #1 chk("s4_held", 32'(gnt_o), 32'h2);
        tick();
        chk("s4_m0_gnt", 32'(gnt_o), 32'h1);
        tick();
        chk("s4_m0_ack", 32'(m0_ack_o), 32'h1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // 5: reset mid-beat during G1
        m1_adr_i = 13'h0010; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        tick();
        chk("s5_m1_ack_pre", 32'(m1_ack_o), 32'h1);
        sys_rst_i = 1'b0;
        #1;
        chk("s5_gnt", 32'(gnt_o), 32'h0);
        chk("s5_m1_ack", 32'(m1_ack_o), 32'h0);
        chk("s5_scyc", 32'(s_cyc_o), 32'h0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();
        sys_rst_i = 1'b1;
        chk("s5_idle", 32'(gnt_o), 32'h0);
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        tick();
        chk("s5_tie_m0", 32'(gnt_o), 32'h1);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        tick();

        // 6: spurious ack in IDLE is discarded
        spur_ack = 1'b1;
        #1;
        chk("s6_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("s6_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        chk("s6_m0_ack2", 32'(m0_ack_o), 32'h0);
        chk("s6_m1_ack2", 32'(m1_ack_o), 32'h0);
        spur_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
